// File: rtl/sync_invert_bank.sv
// Bank of independent input channels: synchroniser, programmable glitch filter
// and a per-channel output mode (pass / invert / toggle-on-rise / force-low).
module sync_invert_bank #(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_BITS   = 4,
  parameter int CH_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [CHANNELS-1:0]  in_data,
  input  logic                 cfg_wr,
  input  logic [CH_BITS-1:0]   cfg_ch,
  input  logic [1:0]           cfg_mode,
  input  logic [FILT_BITS-1:0] cfg_thresh,
  output logic [CHANNELS-1:0]  out_data,
  output logic [CHANNELS-1:0]  out_edge,
  output logic                 cfg_err
);

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_INVERT = 2'b01;
  localparam logic [1:0] MODE_TOGGLE = 2'b10;
  localparam logic [CH_BITS:0] CH_LIMIT = (CH_BITS+1)'(CHANNELS);

  logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]  s;
  logic [CHANNELS-1:0]  f;
  logic [CHANNELS-1:0]  f_prev;
  logic [FILT_BITS-1:0] cnt    [CHANNELS];
  logic [1:0]           mode   [CHANNELS];
  logic [FILT_BITS-1:0] thresh [CHANNELS];
  logic [CHANNELS-1:0]  wr_hit;
  logic [CHANNELS-1:0]  out_next;
  logic                 ch_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in_data;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign ch_bad = ({1'b0, cfg_ch} >= CH_LIMIT);

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++)
      wr_hit[i] = cfg_wr && (cfg_ch == CH_BITS'(i));
  end

  // A config write clears the counter after the filter decision, so a
  // coincident filter update still lands on f while cnt ends at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f      <= '0;
      f_prev <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i]    <= '0;
        mode[i]   <= MODE_INVERT;
        thresh[i] <= '0;
      end
    end else begin
      if (ena) f_prev <= f;
      for (int i = 0; i < CHANNELS; i++) begin
        if (ena) begin
          if (s[i] != f[i] && cnt[i] == thresh[i]) begin
            f[i]   <= s[i];
            cnt[i] <= '0;
          end else if (s[i] != f[i]) begin
            if (cnt[i] != '1) cnt[i] <= cnt[i] + FILT_BITS'(1);
          end else begin
            cnt[i] <= '0;
          end
        end
        if (wr_hit[i]) begin
          mode[i]   <= cfg_mode;
          thresh[i] <= cfg_thresh;
          cnt[i]    <= '0;
        end
      end
    end
  end

  always_comb begin
    out_next = out_data;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode[i])
        MODE_PASS:   out_next[i] = f[i];
        MODE_INVERT: out_next[i] = ~f[i];
        MODE_TOGGLE: out_next[i] = out_data[i] ^ (f[i] & ~f_prev[i]);
        default:     out_next[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '1;
      out_edge <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_wr && ch_bad;
      if (ena) begin
        out_data <= out_next;
        out_edge <= out_next ^ out_data;
      end else begin
        out_edge <= '0;
      end
    end
  end

endmodule
